jk_ff_bank: RTL
===============

# jk_ff_bank

Parametrised bank of `WIDTH` independent edge-triggered flip-flops that share one clock, one enable and one run-time mode select. Each bit can be driven as a JK, SR, D or T element. The bank is the general-purpose successor to the single-bit JK/SR flip-flop and is used wherever the design needs a multi-bit control/status register with per-bit set/reset/toggle semantics. It adds a defined toggle on J=K=1, sticky illegal-input flags, a change pulse and an optional transition counter.

## Interface
Parameters:
- `WIDTH`, default 8: number of flip-flops (1..64).
- `PR_VAL`, default all ones: `WIDTH`-bit value loaded by `PR`.
- `CNT_W`, default 16: width of `TCNT`.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `CLR`, in, 1: reset, synchronous, active-high.
- `PR`, in, 1: synchronous preset, active-high; loads `PR_VAL`.
- `EN`, in, 1: update enable for J/K evaluation.
- `MODE`, in, 2: selects the per-bit function.
  - 00 = JK.
  - 01 = SR (J=S, K=R).
  - 10 = D (J=D, K ignored).
  - 11 = T (J=T, K ignored).
- `J`, in, WIDTH: per-bit J / S / D / T input.
- `K`, in, WIDTH: per-bit K / R input.
- `ILL_CLR`, in, 1: clears `ILLEGAL` flags.
- `Q`, out, WIDTH: true outputs.
- `QB`, out, WIDTH: complement outputs; always equal to ~`Q`.
- `ILLEGAL`, out, WIDTH: sticky per-bit flag for S=R=1 in SR mode.
- `CHG`, out, 1: high for one cycle after any edge at which `Q` changed.
- `TCNT`, out, CNT_W: count of bit transitions (see Configuration).

## Operation
- Priority per edge, highest first: `CLR`, then `PR`, then `EN`-qualified mode logic. When `EN`=0, all bits hold.
- `CLR`=1 sets:
  - `Q`=0, `QB`=all ones.
  - `ILLEGAL`=0, `CHG`=0, `TCNT`=0.
- `PR`=1 with `CLR`=0:
  - `Q`=`PR_VAL`.
  - `ILLEGAL` is unchanged.
  - `CHG`/`TCNT` update as for any other `Q` change.
- JK mode, per bit:
  - 00 holds.
  - 10 sets.
  - 01 clears.
  - 11 toggles.
- SR mode, per bit:
  - 00 holds.
  - 10 sets.
  - 01 clears.
  - 11 holds and sets `ILLEGAL[i]`.
- D mode: `Q[i]`=`J[i]`.
- T mode: `Q[i]` toggles when `J[i]`=1, otherwise holds.
- No X is ever produced by any input combination.
- `ILLEGAL`:
  - Set by the SR 11 condition (only when `EN`=1, `CLR`=0, `PR`=0).
  - Cleared by `ILL_CLR`=1 or `CLR`.
  - If set and `ILL_CLR` happen on the same edge, set wins for that bit; other bits clear.
- `CHG`: registered as (next `Q` != current `Q`) on every edge; it is 0 after `CLR`.
- `MODE` is sampled every edge, so a mode change takes effect on the same edge.

## Timing
- Latency: inputs sampled at edge n, and `Q`/`QB`/`ILLEGAL`/`CHG`/`TCNT` are valid after edge n. All outputs are registered; there is no combinational input-to-output path.
- Reset mid-operation:
  - `CLR` overrides everything on that edge, including `PR` and a pending illegal set.
  - The first evaluation after reset is the edge following `CLR` deassertion.
- `TCNT` update on an edge: `TCNT` += popcount(next `Q` ^ `Q`).
  - The sum is computed at CNT_W+7 bits.
  - The result saturates at 2^CNT_W−1; it does not wrap.
  - Once saturated it holds until `CLR`.
- `PR` while `Q`=`PR_VAL`: `CHG`=0 and `TCNT` is unchanged.

## Configuration
- Macro `JK_FF_BANK_TCNT_EN`.
- Defined: the saturating transition counter is implemented as described.
- Undefined:
  - No counter logic is built.
  - `TCNT` is tied to 0.
  - The port list is unchanged.
  - All other behaviour is identical.

## Test plan
- Reset and preset: WIDTH=8, `CLR`=1 for one edge → `Q`=0x00, `QB`=0xFF, `CHG`=0, `TCNT`=0. Then `CLR`=0, `PR`=1 → `Q`=0xFF, `CHG`=1, `TCNT`=8. Then `CLR`=1 and `PR`=1 together → `Q`=0x00.
- JK mode from `Q`=0x0F, `EN`=1, `MODE`=00, `J`=0xF0, `K`=0x3C → `Q`=0xF3 (bits 7:6 set, 5:4 toggle to 1, 3:2 clear, 1:0 hold), `CHG`=1, `TCNT` += 6.
- SR illegal from `Q`=0x00, `MODE`=01, `J`=0x81, `K`=0x01:
  - Result: `Q`=0x80, `ILLEGAL`=0x01.
  - Next edge `ILL_CLR`=1, `J`=0x02, `K`=0x02 → `ILLEGAL`=0x02.
  - Next edge `ILL_CLR`=1, `J`=`K`=0 → `ILLEGAL`=0x00.
- D/T/enable from `Q`=0x00:
  - `MODE`=10, `J`=0xA5 → `Q`=0xA5.
  - `MODE`=11, `J`=0xFF → `Q`=0x5A.
  - `EN`=0, `J`=0xFF → `Q` holds at 0x5A and `CHG`=0.
- Counter saturation: CNT_W=4, `MODE`=11, `J`=0xFF for 2 edges → `TCNT`=15 (16 saturates), and stays 15 on further toggles. With the macro undefined → `TCNT`=0 throughout.

Source files
------------

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH flip-flops; each bit acts as a JK, SR, D or T element selected by MODE.
// Define JK_FF_BANK_TCNT_EN to build the saturating transition counter on TCNT.
module jk_ff_bank #(
   parameter int unsigned             WIDTH  = 8,
   parameter logic [WIDTH-1:0]        PR_VAL = {WIDTH{1'b1}},
   parameter int unsigned             CNT_W  = 16
) (
   input  logic               CLK,
   input  logic               CLR,
   input  logic               PR,
   input  logic               EN,
   input  logic [1:0]         MODE,
   input  logic [WIDTH-1:0]   J,
   input  logic [WIDTH-1:0]   K,
   input  logic               ILL_CLR,
   output logic [WIDTH-1:0]   Q,
   output logic [WIDTH-1:0]   QB,
   output logic [WIDTH-1:0]   ILLEGAL,
   output logic               CHG,
   output logic [CNT_W-1:0]   TCNT
);

   typedef enum logic [1:0] {
      M_JK = 2'b00,
      M_SR = 2'b01,
      M_D  = 2'b10,
      M_T  = 2'b11
   } mode_e;

   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] ill_set;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      q_nxt   = Q;
      ill_set = '0;
      if (PR) begin
         q_nxt = PR_VAL;
      end else if (EN) begin
         case (mode_e'(MODE))
            M_JK: q_nxt = (J & ~Q) | (~K & Q);
            M_SR: begin
               q_nxt   = (J & ~K) | (Q & (~K | J));
               ill_set = J & K;
            end
            M_D:  q_nxt = J;
            M_T:  q_nxt = Q ^ J;
            default: q_nxt = Q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         Q       <= '0;
         ILLEGAL <= '0;
         CHG     <= 1'b0;
      end else begin
         Q       <= q_nxt;
         ILLEGAL <= (ILL_CLR ? '0 : ILLEGAL) | ill_set;
         CHG     <= (q_nxt != Q);
      end
   end

   assign QB = ~Q;

`ifdef JK_FF_BANK_TCNT_EN
   localparam int unsigned SUM_W = CNT_W + 7;

   logic [WIDTH-1:0] diff;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] tcnt_nxt;

   // Add this edge's transitions at a wider width, then clamp instead of wrapping.
   always_comb begin
      diff = q_nxt ^ Q;
      sum  = SUM_W'(TCNT);
      for (int i = 0; i < WIDTH; i++) begin
         sum = sum + SUM_W'(diff[i]);
      end
      if (|sum[SUM_W-1:CNT_W]) tcnt_nxt = '1;
      else                     tcnt_nxt = sum[CNT_W-1:0];
   end

   always_ff @(posedge CLK) begin
      if (CLR) TCNT <= '0;
      else     TCNT <= tcnt_nxt;
   end
`else
   assign TCNT = '0;
`endif

endmodule
